// File: rtl/direction_key_conditioner.sv
// Direction key conditioner: synchronises, debounces and chord-filters
// four active-low buttons into a one-hot direction with a press pulse.
module direction_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNTER_WIDTH   = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys_n,
  output logic [3:0] player_direction,
  output logic [3:0] direction_pulse,
  output logic       multi_press
);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST =
    COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]               sync_a;
  logic [3:0]               s;
  state_t                   state;
  state_t                   state_next;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] count_next;
  logic [3:0]               candidate;
  logic [3:0]               cand_next;
  logic [3:0]               dir_next;
  logic [3:0]               pulse_next;
  logic                     multi_next;
  logic                     one_hot;
  logic                     many;

  assign one_hot = (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
  assign many    = (s != 4'b0000) && !one_hot;

  // Two-flop synchroniser on the inverted (active-high) keys
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 4'b0000;
      s      <= 4'b0000;
    end else begin
      sync_a <= ~keys_n;
      s      <= sync_a;
    end
  end

  // State, counter, candidate and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      candidate        <= 4'b0000;
      player_direction <= 4'b0000;
      direction_pulse  <= 4'b0000;
      multi_press      <= 1'b0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      candidate        <= cand_next;
      player_direction <= dir_next;
      direction_pulse  <= pulse_next;
      multi_press      <= multi_next;
    end
  end

  // Next state: counter restarts on every state change, never passes LAST
  always_comb begin
    state_next = state;
    count_next = count;
    cand_next  = candidate;
    unique case (state)
      IDLE: begin
        if (one_hot) begin
          cand_next  = s;
          count_next = '0;
          state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (s != candidate) begin
          count_next = '0;
          state_next = IDLE;
        end else if (count == LAST) begin
          count_next = '0;
          state_next = PRESSED;
        end else begin
          count_next = count + 1'b1;
        end
      end
      PRESSED: begin
        if (s != candidate) begin
          count_next = '0;
          state_next = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (s == candidate) begin
          count_next = '0;
          state_next = PRESSED;
        end else if (count == LAST) begin
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs for the next cycle, derived from the transition being taken
  always_comb begin
    multi_next = (state == IDLE) && many;
    pulse_next = 4'b0000;
    dir_next   = 4'b0000;
    if (state == DEB_PRESS && state_next == PRESSED)
      pulse_next = candidate;
    if (state_next == PRESSED || state_next == DEB_RELEASE)
      dir_next = cand_next;
  end

endmodule
